// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD converter among NREQ requesters.
// Out-of-range operands bypass the converter; a stuck converter is bounded by TIMEOUT.
module bcd_conv_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   op_in,
    output logic [NREQ-1:0]      ack,
    output logic [15:0]          bcd_out,
    output logic [1:0]           err,
    output logic                 busy,
    output logic [15:0]          core_op_a,
    output logic                 core_init,
    input  logic                 core_done,
    input  logic [15:0]          core_result
);

    localparam int          IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]  TO     = 8'(TIMEOUT);
    localparam logic [15:0] MAX_OP = 16'd9999;

    typedef enum logic [2:0] {IDLE, START, WAIT, RELEASE, RESP} state_t;

    state_t        state, state_n;
    logic [IW-1:0] grant_q, grant_n, last_grant, last_n, pick;
    logic          found;
    logic [15:0]   op_q, op_n, bcd_n;
    logic [1:0]    err_n;
    logic [7:0]    timer, timer_n, timer_inc;
    logic [15:0]   op_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        assign op_arr[g] = op_in[16*g +: 16];
        assign ack[g]    = (state == RESP) && (grant_q == IW'(g));
    end

    assign busy      = (state != IDLE);
    assign core_init = (state == START) || (state == WAIT);
    assign core_op_a = op_q;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = last_grant;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[IW'((int'(last_grant) + k) % NREQ)]) begin
                found = 1'b1;
                pick  = IW'((int'(last_grant) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_n   = state;
        grant_n   = grant_q;
        last_n    = last_grant;
        op_n      = op_q;
        bcd_n     = bcd_out;
        err_n     = err;
        timer_n   = timer;
        timer_inc = timer + 8'd1;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_n = pick;
                    op_n    = op_arr[pick];
                    bcd_n   = '0;
                    timer_n = '0;
                    if (op_arr[pick] > MAX_OP) begin
                        err_n   = 2'b01;
                        state_n = RESP;
                    end else begin
                        err_n   = 2'b00;
                        state_n = START;
                    end
                end
            end
            START: begin
                timer_n = '0;
                state_n = WAIT;
            end
            WAIT: begin
                timer_n = timer_inc;
                if (core_done) begin
                    bcd_n   = core_result;
                    err_n   = 2'b00;
                    timer_n = '0;
                    state_n = RELEASE;
                end else if (timer_inc == TO) begin
                    bcd_n   = '0;
                    err_n   = 2'b10;
                    timer_n = '0;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                // Wait for the converter to drop done before the next request can start it.
                timer_n = timer_inc;
                if (!core_done) begin
                    state_n = RESP;
                end else if (timer_inc == TO) begin
                    err_n   = 2'b10;
                    state_n = RESP;
                end
            end
            RESP: begin
                last_n  = grant_q;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant_q    <= '0;
            last_grant <= IW'(NREQ - 1);
            op_q       <= '0;
            bcd_out    <= '0;
            err        <= '0;
            timer      <= '0;
        end else begin
            state      <= state_n;
            grant_q    <= grant_n;
            last_grant <= last_n;
            op_q       <= op_n;
            bcd_out    <= bcd_n;
            err        <= err_n;
            timer      <= timer_n;
        end
    end

endmodule

// File: doc/bcd_conv_arbiter.md
BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

Interface
REQ-001 The block SHALL take parameter NREQ, default 3: number of requesters sharing one binary-to-BCD converter.
REQ-002 The block SHALL take parameter TIMEOUT, default 255: maximum cycles spent waiting on the converter (8-bit counter).
REQ-003 The block SHALL have port CLK, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req, input, NREQ bits: per-requester conversion request, held high until that requester's ack.
REQ-006 The block SHALL have port op_in, input, 16*NREQ bits: binary operand of requester i on bits [16i+15:16i].
REQ-007 The block SHALL have port ack, output, NREQ bits: one-hot, one-cycle completion pulse.
REQ-008 The block SHALL have port bcd_out, output, 16 bits: {MIL,CENT,DEC,UNIT}, valid only while any ack bit is high.
REQ-009 The block SHALL have port err, output, 2 bits: 00 ok, 01 operand out of range, 10 converter timeout; valid with ack.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-011 The block SHALL have port core_op_a, output, 16 bits: operand driven to the converter.
REQ-012 The block SHALL have port core_init, output, 1 bit: converter start level.
REQ-013 The block SHALL have port core_done, input, 1 bit: converter completion.
REQ-014 The block SHALL have port core_result, input, 16 bits: converter BCD result.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, START, WAIT, RELEASE, RESP.
REQ-016 IDLE with any req bit high: grant the lowest index at or above (last_grant+1) mod NREQ, wrapping; latch operand and index; go to START.
REQ-017 IDLE grant with latched operand > 9999: skip the converter, set err=01 and bcd_out=0, and go directly to RESP.
REQ-018 START: drive core_op_a=latched operand and core_init=1, clear the timer, go to WAIT.
REQ-019 core_op_a SHALL hold the latched operand from START through RELEASE; req and op_in changes after the grant SHALL be ignored.
REQ-020 WAIT: hold core_init=1 and increment the timer each cycle.
REQ-021 WAIT with core_done=1: latch core_result into bcd_out with err=00 and go to RELEASE.
REQ-022 WAIT with the timer reaching TIMEOUT and core_done=0: set err=10 and bcd_out=0, go to RELEASE.
REQ-023 RELEASE: drive core_init=0 and stay until core_done=0, then go to RESP.
REQ-024 RELEASE SHALL also exit to RESP after TIMEOUT cycles, with err forced to 10.
REQ-025 RESP: assert ack[granted index] for exactly one cycle, set last_grant to the granted index, go to IDLE.
REQ-026 A req still high in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-027 Latency with a well-behaved core: ack SHALL be high 2 cycles after the edge at which core_done is first sampled high, provided core_done falls within 1 cycle of core_init falling.
REQ-028 Simultaneous requests SHALL be served one per transaction in round-robin order; no requester SHALL wait more than NREQ-1 transactions.
REQ-029 At most one ack bit SHALL be high in any cycle.
REQ-030 The bcd_out and err values SHALL be held from latching until the next grant.

Reset
REQ-031 Asserting reset low at any time, mid-transaction included, SHALL force asynchronously: state=IDLE, ack=0, bcd_out=0, err=00, busy=0, core_init=0, core_op_a=0, timer=0, last_grant=NREQ-1 (so index 0 wins first).
REQ-032 A transaction interrupted by reset SHALL produce no ack; its requester SHALL re-request.

Verification
REQ-033 Scenario: req=001, op0=1234, core model done after 20 cycles -> ack=001 once, bcd_out=16'h1234, err=00.
REQ-034 Scenario: req=111 held, ops 5/9999/42 -> acks in order 001, 010, 100 with bcd_out 0005, 9999, 0042; never two acks in one cycle.
REQ-035 Scenario: op1=10000 on req=010 -> ack=010 within 3 cycles, err=01, bcd_out=0, core_init never high.
REQ-036 Scenario: core_done stuck 0 -> ack after TIMEOUT cycles in WAIT, err=10, core_init low afterwards.
REQ-037 Scenario: reset pulled low during WAIT -> busy=0 and core_init=0 immediately, no ack; after release, req=001 is served normally.
REQ-038 Scenario: core_done left high 10 cycles after core_init falls -> block stays in RELEASE and ack follows the done fall by 1 cycle.
